regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the microprocessor datapath, the next generation of the 8-bit two-read/one-write `RegisterFile`. Data width, depth and read-port count are configurable. Reads are registered with per-port valid flags. Register 0 is hardwired to zero. A sequenced bulk-clear command is provided. The block sits between decode (port addresses) and the execute stage (RD operands, WriteData from write-back).

## Interface
Parameters:
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- RA  in  NUM_READ*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- regReadEnable  in  NUM_READ  per-port read request
- RD  out  NUM_READ*DATA_WIDTH  registered read data, packed the same way as RA
- RDValid  out  NUM_READ  one-cycle pulse: RD slice of port i updated this cycle
- A3  in  ADDR_WIDTH  write address
- WriteData  in  DATA_WIDTH  write data
- regWriteEnable  in  1  write request
- clearReq  in  1  start a bulk clear
- busy  out  1  high while a clear is in progress

## Operation
- Array: DEPTH entries of DATA_WIDTH bits. rst asynchronously zeroes all entries, RD, RDValid and busy, and forces state to IDLE.
- Register 0: writes to A3=0 are discarded; reads of address 0 return 0.
- Write: in IDLE, regWriteEnable=1 with A3≠0 stores WriteData at the rising edge.
- Read: in IDLE, regReadEnable[i]=1 at edge k captures entry RA[i] into RD[i] and sets RDValid[i]=1 for the cycle after edge k. With regReadEnable[i]=0, RD[i] holds its value and RDValid[i]=0. Ports are fully independent, and any ports may read the same address.
- Same-edge read/write to the same nonzero address: see Configuration.
- State machine, two states:
  - IDLE: clearReq=1 → CLEAR, with the sweep pointer at 1 and busy=1 from the next cycle.
  - CLEAR: zeroes entry[ptr] each cycle and increments ptr. After zeroing entry DEPTH-1 → IDLE, with busy=0 on the following cycle. The pointer wraps implicitly and is not used after the last entry.
  - During CLEAR, write and read requests are dropped: no array update, RDValid=0, RD held. clearReq is ignored.
  - clearReq together with regWriteEnable in IDLE: the write is performed, then the clear sweeps it away.
- rst asserted mid-clear: immediate return to IDLE with all entries zeroed.

## Timing
- Read latency: 1 cycle, address to RD/RDValid.
- Write-to-read latency: 1 cycle with bypass, or 2 cycles without (read issued after the write edge).
- Clear duration: busy high for exactly DEPTH-1 cycles (31 at default). The first accepted access is at the edge after busy falls.
- Reset values: RD=0, RDValid=0, busy=0.
- No combinational path from inputs to outputs.

## Configuration
- REGFILE_BYPASS_EN defined: a read at the same edge as a write to the same nonzero address returns the new WriteData.
- REGFILE_BYPASS_EN undefined: the same read returns the pre-write contents.
- The macro has no effect on address 0 or during CLEAR.

## Structure
- Package regfile_pkg holds:
  - the state enum (IDLE, CLEAR)
  - default width/depth constants
  - a read-slice helper function for packed ports
- Sub-module regfile_read_port: one registered read port (mux, bypass compare, RD/RDValid flops). It is instantiated NUM_READ times in a generate loop.

## Test plan
Defaults: DATA_WIDTH=8, ADDR_WIDTH=5, NUM_READ=2.
- After reset, read addresses 0 and 31 on both ports → RD=0/0, RDValid=11 one cycle later, busy=0.
- Write 42 to r2, then read r2 on port 0 and r1 on port 1 → RD0=42, RD1=0. Write 99 to r0, then read r0 → 0.
- Same-edge write 67 to r1 while reading r1 (r1 previously 5) → RD=67 with REGFILE_BYPASS_EN, RD=5 without.
- Fill r1..r31 with their index values, pulse clearReq:
  - busy high for 31 cycles
  - a write of 77 to r4 and a read during busy are dropped (RDValid=0)
  - afterwards every read returns 0.
- Start a clear, assert rst at cycle 10 of the sweep → busy=0 immediately, all entries read 0, and a new write of 13 to r3 reads back 13.
- Hold regReadEnable=0 for 3 cycles after a valid read of 42 → RD stays 42, RDValid=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   - state_t       : sequencer states (IDLE, CLEAR)
//   - DEF_*         : default data width, address width and read-port count
//   - MAX_BUS       : widest packed port bus the slice helper handles
//   - bus_slice()   : extracts field idx (width w) from a packed port bus
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_NUM_READ   = 2;

  localparam int unsigned MAX_BUS = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Returns the bus shifted so that field idx sits at bit 0; the caller
  // size-casts the result down to the field width.
  function automatic logic [MAX_BUS-1:0] bus_slice(
    input logic [MAX_BUS-1:0] bus,
    input int unsigned        idx,
    input int unsigned        w
  );
    return bus >> (idx * w);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port of regfile_mp.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   en         : read request already qualified with the sequencer state
//   addr       : read address
//   mem_flat   : whole register array, entry e at [e*DATA_WIDTH +: DATA_WIDTH]
//   wr_en/wr_addr/wr_data : same-edge write (wr_en already excludes address 0)
//   rd, rd_valid : registered read data and one-cycle update pulse
// Macro REGFILE_BYPASS_EN: a same-edge write to the read address returns
// the new data instead of the pre-write contents.
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DEPTH*DATA_WIDTH-1:0] mem_flat,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DATA_WIDTH-1:0]       rd,
  output logic                        rd_valid
);

  logic [DATA_WIDTH-1:0] rdata;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata = mem_flat[addr*DATA_WIDTH +: DATA_WIDTH];
    if (wr_en && (wr_addr == addr)) rdata = wr_data;
    if (addr == '0) rdata = '0;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    rdata = mem_flat[addr*DATA_WIDTH +: DATA_WIDTH];
    if (addr == '0) rdata = '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd       <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en;
      if (en) rd <= rdata;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file, register 0 hardwired
// to zero, registered reads with per-port valid pulses, sequenced bulk clear.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   RA              : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   regReadEnable   : per-port read request
//   RD              : packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   RDValid         : per-port one-cycle pulse, RD slice updated
//   A3, WriteData, regWriteEnable : write port
//   clearReq        : start bulk clear of entries 1..DEPTH-1
//   busy            : clear in progress, all accesses dropped
// Macro REGFILE_BYPASS_EN: same-edge write-to-read forwarding (see read port).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_READ   = DEF_NUM_READ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] RA,
  input  logic [NUM_READ-1:0]            regReadEnable,
  output logic [NUM_READ*DATA_WIDTH-1:0] RD,
  output logic [NUM_READ-1:0]            RDValid,
  input  logic [ADDR_WIDTH-1:0]          A3,
  input  logic [DATA_WIDTH-1:0]          WriteData,
  input  logic                           regWriteEnable,
  input  logic                           clearReq,
  output logic                           busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] mem_flat;
  logic                    idle;
  logic                    wr_ok;
  logic [MAX_BUS-1:0]      ra_ext;

  assign idle   = (state == IDLE);
  assign wr_ok  = idle && regWriteEnable && (A3 != '0);
  assign busy   = (state == CLEAR);
  assign ra_ext = MAX_BUS'(RA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A write accepted alongside clearReq lands first and is then
          // swept away by the clear.
          if (wr_ok) mem[A3] <= WriteData;
          if (clearReq) begin
            state <= CLEAR;
            ptr   <= ADDR_WIDTH'(1);
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + ADDR_WIDTH'(1);
          if (ptr == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign mem_flat[e*DATA_WIDTH +: DATA_WIDTH] = mem[e];
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] port_addr;
    assign port_addr = ADDR_WIDTH'(bus_slice(ra_ext, i, ADDR_WIDTH));

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .en       (regReadEnable[i] && idle),
      .addr     (port_addr),
      .mem_flat (mem_flat),
      .wr_en    (wr_ok),
      .wr_addr  (A3),
      .wr_data  (WriteData),
      .rd       (RD[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid (RDValid[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed stimulus against a behavioural
// array model; expected read data and per-cycle busy/valid are queued by
// the stimulus and consumed by an independent monitor.
module tb_regfile_mp;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] RA = '0;
  logic [NR-1:0]    regReadEnable = '0;
  logic [NR*DW-1:0] RD;
  logic [NR-1:0]    RDValid;
  logic [AW-1:0]    A3 = '0;
  logic [DW-1:0]    WriteData = '0;
  logic             regWriteEnable = 1'b0;
  logic             clearReq = 1'b0;
  logic             busy;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
    .clk(clk), .rst(rst), .RA(RA), .regReadEnable(regReadEnable),
    .RD(RD), .RDValid(RDValid), .A3(A3), .WriteData(WriteData),
    .regWriteEnable(regWriteEnable), .clearReq(clearReq), .busy(busy)
  );

  typedef struct {
    logic [NR-1:0] valid;
    logic          busy;
  } rec_t;

  rec_t             recq[$];
  logic [DW-1:0]    dq0[$];
  logic [DW-1:0]    dq1[$];

  int unsigned      ref_mem[DEPTH];
  int               busy_left = 0;
  int               n_checks  = 0;
  int               n_fail    = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned model_read(input int unsigned addr, input logic we,
                                             input int unsigned a3, input int unsigned wd);
    if (addr == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (we && a3 == addr) return wd;
`endif
    return ref_mem[addr];
  endfunction

  // Drives one cycle of inputs and records what the next edge must produce.
  task automatic step(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic we, input logic [4:0] a3, input logic [7:0] wd,
                      input logic clr);
    rec_t        r;
    int unsigned addr[2];
    @(negedge clk);
    regReadEnable  = ren;
    RA             = {ra1, ra0};
    regWriteEnable = we;
    A3             = a3;
    WriteData      = wd;
    clearReq       = clr;
    addr[0] = ra0;
    addr[1] = ra1;
    r.valid = '0;
    if (busy_left == 0) begin
      for (int p = 0; p < NR; p++) begin
        if (ren[p]) begin
          logic [DW-1:0] v;
          v = DW'(model_read(addr[p], we, a3, wd));
          if (p == 0) dq0.push_back(v); else dq1.push_back(v);
          r.valid[p] = 1'b1;
        end
      end
      if (we && a3 != 0) ref_mem[a3] = wd;
      if (clr) begin
        busy_left = DEPTH - 1;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
      end
    end else begin
      busy_left--;
    end
    r.busy = (busy_left != 0);
    recq.push_back(r);
  endtask

  task automatic idle_step();
    step(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    regReadEnable = '0; regWriteEnable = 1'b0; clearReq = 1'b0;
    #1;
    check("busy_async_rst", busy, 0);
    check("rdvalid_async_rst", RDValid, 0);
    check("rd_async_rst", RD, 0);
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
    busy_left = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one record per driven cycle, sampled 1 time unit after the edge.
  initial begin : monitor
    logic [DW-1:0] last_rd[NR];
    rec_t          r;
    for (int p = 0; p < NR; p++) last_rd[p] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int p = 0; p < NR; p++) last_rd[p] = '0;
      end else if (recq.size() > 0) begin
        r = recq.pop_front();
        check("busy", busy, r.busy);
        for (int p = 0; p < NR; p++) begin
          check($sformatf("rdvalid%0d", p), RDValid[p], r.valid[p]);
          if (r.valid[p]) begin
            if ((p == 0 && dq0.size() == 0) || (p == 1 && dq1.size() == 0)) begin
              check($sformatf("rd%0d_queue_nonempty", p), 0, 1);
            end else begin
              last_rd[p] = (p == 0) ? dq0.pop_front() : dq1.pop_front();
              check($sformatf("rd%0d", p), RD[p*DW +: DW], last_rd[p]);
            end
          end else begin
            check($sformatf("rd%0d_hold", p), RD[p*DW +: DW], last_rd[p]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_rd", RD, 0);
    check("reset_rdvalid", RDValid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    // reset contents on both ports
    step(2'b11, 5'd0, 5'd31, 1'b0, 5'd0, 8'd0, 1'b0);
    step(2'b11, 5'd31, 5'd0, 1'b0, 5'd0, 8'd0, 1'b0);

    // basic write/read, register 0
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 8'd42, 1'b0);
    step(2'b11, 5'd2, 5'd1, 1'b0, 5'd0, 8'd0, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 8'd99, 1'b0);
    step(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 8'd0, 1'b0);

    // same-edge write/read of r1 (previously 5), both ports
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd1, 8'd5, 1'b0);
    step(2'b11, 5'd1, 5'd1, 1'b1, 5'd1, 8'd67, 1'b0);
    step(2'b01, 5'd1, 5'd0, 1'b0, 5'd0, 8'd0, 1'b0);
    // same-edge write to r0 while reading r0
    step(2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 8'd55, 1'b0);

    // valid read of 42 then three cycles with no request: RD holds
    step(2'b11, 5'd2, 5'd2, 1'b0, 5'd0, 8'd0, 1'b0);
    repeat (3) idle_step();

    // fill, clear, dropped accesses during busy, then read everything
    for (int k = 1; k < DEPTH; k++) step(2'b00, 5'd0, 5'd0, 1'b1, 5'(k), 8'(k), 1'b0);
    step(2'b11, 5'd7, 5'd31, 1'b0, 5'd0, 8'd0, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 8'd200, 1'b1);
    step(2'b11, 5'd4, 5'd5, 1'b1, 5'd4, 8'd77, 1'b0);
    step(2'b11, 5'd4, 5'd4, 1'b0, 5'd0, 8'd0, 1'b1);
    repeat (DEPTH) step(2'b11, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        1'b1, 5'($urandom_range(1, 31)), 8'($urandom), 1'b0);
    for (int k = 0; k < DEPTH; k++) step(2'b11, 5'(k), 5'(DEPTH - 1 - k), 1'b0, 5'd0, 8'd0, 1'b0);

    // clear interrupted by reset at sweep cycle 10
    for (int k = 1; k < DEPTH; k++) step(2'b00, 5'd0, 5'd0, 1'b1, 5'(k), 8'(k + 100), 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 8'd0, 1'b1);
    repeat (9) idle_step();
    apply_reset();
    for (int k = 0; k < DEPTH; k++) step(2'b11, 5'(k), 5'(k ^ 5), 1'b0, 5'd0, 8'd0, 1'b0);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 8'd13, 1'b0);
    step(2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 8'd0, 1'b0);

    // randomized traffic with occasional clears
    repeat (400) begin
      step(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
           1'($urandom), 5'($urandom), 8'($urandom), ($urandom_range(0, 59) == 0));
    end
    repeat (DEPTH + 2) idle_step();

    @(negedge clk);
    check("queues_drained", recq.size() + dq0.size() + dq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
